// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes, state, ALU op and select encodings for the multicycle control unit
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2   = 2'd0;
  localparam logic [1:0] B_IMM   = 2'd1;
  localparam logic [1:0] B_FOUR  = 2'd2;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  function automatic logic is_legal(input logic [6:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
           (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP) || (opc == OPC_OP_IMM);
  endfunction

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// rtl/riscv_multicycle_control_if.sv - instruction fields, memory handshake and datapath controls
interface riscv_multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] wb_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct3, funct7_5, mem_ready, branch_taken,
    output pc_write, pc_src, ir_write, reg_write, mem_req, mem_we, wb_sel,
           alu_src_a, alu_src_b, alu_op, trap, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready, branch_taken,
    input  pc_write, pc_src, ir_write, reg_write, mem_req, mem_we, wb_sel,
           alu_src_a, alu_src_b, alu_op, trap, trap_cause
  );
endinterface

// File: rtl/riscv_alu_decode.sv
// rtl/riscv_alu_decode.sv - opcode/funct3/funct7_5 to ALU operation
module riscv_alu_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  logic is_op;

  assign is_op = (opcode == OPC_OP);

  always_comb begin
    alu_op = ALU_ADD;
    if (is_op || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// rtl/riscv_multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory stall and trap
module riscv_multicycle_control
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_multicycle_control_if.master    ctrl
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    cause_q, cause_next;
  logic [3:0]    dec_alu_op;
  logic          waiting, timeout;

  riscv_alu_decode u_alu_decode (
    .opcode   (ctrl.opcode),
    .funct3   (ctrl.funct3),
    .funct7_5 (ctrl.funct7_5),
    .alu_op   (dec_alu_op)
  );

  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !ctrl.mem_ready;
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cause_q  <= TC_NONE;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      // Count only consecutive stall cycles within a single state
      if (state_next != state || !waiting) wait_cnt <= '0;
      else                                 wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next      = state;
    cause_next      = cause_q;
    ctrl.pc_write   = 1'b0;
    ctrl.pc_src     = PC_PLUS4;
    ctrl.ir_write   = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.mem_req    = 1'b0;
    ctrl.mem_we     = 1'b0;
    ctrl.wb_sel     = WB_ALU;
    ctrl.alu_src_a  = A_RS1;
    ctrl.alu_src_b  = B_RS2;
    ctrl.alu_op     = ALU_ADD;
    ctrl.trap       = 1'b0;
    ctrl.trap_cause = cause_q;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (ctrl.mem_ready) begin
          ctrl.ir_write = 1'b1;
          state_next    = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = TC_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (is_legal(ctrl.opcode)) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          cause_next = TC_ILLEGAL;
        end
      end

      S_EXEC: begin
        ctrl.alu_op    = dec_alu_op;
        ctrl.alu_src_b = (ctrl.opcode == OPC_OP) ? B_RS2 : B_IMM;
        if (ctrl.opcode == OPC_LUI)
          ctrl.alu_src_a = A_ZERO;
        else if (ctrl.opcode == OPC_AUIPC || ctrl.opcode == OPC_JAL || ctrl.opcode == OPC_BRANCH)
          ctrl.alu_src_a = A_PC;
        if (ctrl.opcode == OPC_BRANCH) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = ctrl.branch_taken ? PC_TARGET : PC_PLUS4;
          state_next    = S_FETCH;
        end else if (ctrl.opcode == OPC_LOAD || ctrl.opcode == OPC_STORE) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (ctrl.opcode == OPC_STORE);
        if (ctrl.mem_ready) begin
          if (ctrl.opcode == OPC_STORE) begin
            ctrl.pc_write = 1'b1;
            state_next    = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = TC_TIMEOUT;
        end
      end

      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        state_next     = S_FETCH;
        if (ctrl.opcode == OPC_LOAD) begin
          ctrl.wb_sel = WB_MEM;
        end else if (ctrl.opcode == OPC_JAL) begin
          ctrl.wb_sel = WB_PC4;
          ctrl.pc_src = PC_TARGET;
        end else if (ctrl.opcode == OPC_JALR) begin
          ctrl.wb_sel = WB_PC4;
          ctrl.pc_src = PC_JALR;
        end
      end

      S_TRAP: begin
        ctrl.trap = 1'b1;
        // Non-halting trap skips the faulting instruction
        if (!TRAP_HALT) begin
          ctrl.pc_write = 1'b1;
          state_next    = S_FETCH;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb/tb_riscv_multicycle_control.sv - directed-vector bench for the multicycle control unit
module tb_riscv_multicycle_control;

  logic clk;
  logic rst_n;
  logic rst_n2;
  int   n_checks;
  int   n_fail;

  riscv_multicycle_control_if if1 ();
  riscv_multicycle_control_if if2 ();

  riscv_multicycle_control #(.MEM_TIMEOUT(16), .TRAP_HALT(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (if1)
  );

  riscv_multicycle_control #(.MEM_TIMEOUT(16), .TRAP_HALT(1'b0)) u_dut_nohalt (
    .clk   (clk),
    .rst_n (rst_n2),
    .ctrl  (if2)
  );

  logic [19:0] outs1, outs2;
  assign outs1 = {if1.pc_write, if1.pc_src, if1.ir_write, if1.reg_write, if1.mem_req, if1.mem_we,
                  if1.wb_sel, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.trap, if1.trap_cause};
  assign outs2 = {if2.pc_write, if2.pc_src, if2.ir_write, if2.reg_write, if2.mem_req, if2.mem_we,
                  if2.wb_sel, if2.alu_src_a, if2.alu_src_b, if2.alu_op, if2.trap, if2.trap_cause};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each cycle slot: inputs driven 2 units after the rising edge, sampled 1 unit later
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input int fw, input int mw, input logic tk,
                           output int cyc, output logic [3:0] ex_op, output logic [1:0] ex_a,
                           output logic [1:0] ex_b, output logic [1:0] pcs,
                           output logic [1:0] wbs, output logic rw);
    int   mc;
    logic fetched;
    logic done;
    if1.opcode       = op;
    if1.funct3       = f3;
    if1.funct7_5     = f75;
    if1.branch_taken = tk;
    cyc = 0; mc = 0; fetched = 1'b0; done = 1'b0;
    ex_op = '0; ex_a = '0; ex_b = '0; pcs = '0; wbs = '0; rw = 1'b0;
    while (!done && cyc < 100) begin
      if1.mem_ready = fetched ? (mc == mw) : (cyc == fw);
      #1;
      if (cyc == fw + 2) begin
        ex_op = if1.alu_op;
        ex_a  = if1.alu_src_a;
        ex_b  = if1.alu_src_b;
      end
      if (if1.reg_write) begin
        rw  = 1'b1;
        wbs = if1.wb_sel;
      end
      if (fetched && if1.mem_req) mc++;
      if (!fetched && if1.ir_write) fetched = 1'b1;
      cyc++;
      if (if1.pc_write) begin
        done = 1'b1;
        pcs  = if1.pc_src;
      end
      next_cycle();
    end
    check("instr_retired", {31'd0, done}, 32'd1);
    if1.mem_ready = 1'b0;
  endtask

  int         cyc;
  logic [3:0] ex_op;
  logic [1:0] ex_a, ex_b, pcs, wbs;
  logic       rw;
  int         n;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rst_n2   = 1'b0;
    if1.opcode = '0; if1.funct3 = '0; if1.funct7_5 = 1'b0; if1.mem_ready = 1'b0; if1.branch_taken = 1'b0;
    if2.opcode = 7'h7f; if2.funct3 = '0; if2.funct7_5 = 1'b0; if2.mem_ready = 1'b1; if2.branch_taken = 1'b0;
    #12;
    check("reset_outs", {12'd0, outs1}, 32'd0);
    check("reset_outs2", {12'd0, outs2}, 32'd0);

    // Release reset: IDLE slot, then ADD instruction checked cycle by cycle
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("idle_outs", {12'd0, outs1}, 32'd0);
    next_cycle();
    if1.opcode = 7'h33; if1.funct3 = 3'd0; if1.funct7_5 = 1'b0; if1.mem_ready = 1'b1;
    #1;
    check("fetch_req", {30'd0, if1.mem_req, if1.mem_we}, 32'h2);
    check("fetch_irw", {31'd0, if1.ir_write}, 32'd1);
    next_cycle();
    if1.mem_ready = 1'b0;
    #1;
    check("decode_quiet", {29'd0, if1.pc_write, if1.reg_write, if1.mem_req}, 32'd0);
    next_cycle();
    #1;
    check("add_exec", {24'd0, if1.alu_op, if1.alu_src_a, if1.alu_src_b}, 32'h0);
    check("add_exec_nopcw", {31'd0, if1.pc_write}, 32'd0);
    next_cycle();
    #1;
    check("add_wb", {26'd0, if1.reg_write, if1.pc_write, if1.pc_src, if1.wb_sel}, 32'h30);
    next_cycle();

    run_instr(7'h33, 3'd0, 1'b0, 1, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("add_fwait_cycles", cyc, 5);

    run_instr(7'h13, 3'd5, 1'b1, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("srai_cycles", cyc, 4);
    check("srai_aluop", ex_op, 7);
    check("srai_srcb", ex_b, 1);

    run_instr(7'h33, 3'd0, 1'b1, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("sub_aluop", ex_op, 1);
    check("sub_srcb", ex_b, 0);

    run_instr(7'h13, 3'd0, 1'b1, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("addi_f7_aluop", ex_op, 0);

    run_instr(7'h33, 3'd7, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("and_aluop", ex_op, 9);

    run_instr(7'h03, 3'd2, 1'b0, 0, 3, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("load_cycles", cyc, 8);
    check("load_wb", {29'd0, rw, wbs}, 32'h5);

    run_instr(7'h23, 3'd2, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("store_cycles", cyc, 4);
    check("store_noregw", {29'd0, rw, pcs}, 32'h0);

    run_instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b1, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("beq_taken", {24'd0, cyc[3:0], rw, 1'b0, pcs}, {24'd0, 4'd3, 1'b0, 1'b0, 2'd1});

    run_instr(7'h63, 3'd0, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("beq_not_taken", {24'd0, cyc[3:0], rw, 1'b0, pcs}, {24'd0, 4'd3, 1'b0, 1'b0, 2'd0});

    run_instr(7'h67, 3'd0, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("jalr", {24'd0, cyc[3:0], pcs, wbs}, {24'd0, 4'd4, 2'd2, 2'd2});

    run_instr(7'h6f, 3'd0, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("jal", {24'd0, cyc[3:0], pcs, wbs}, {24'd0, 4'd4, 2'd1, 2'd2});
    check("jal_srca", ex_a, 1);

    run_instr(7'h37, 3'd0, 1'b0, 0, 0, 1'b0, cyc, ex_op, ex_a, ex_b, pcs, wbs, rw);
    check("lui_srcs", {28'd0, ex_a, ex_b}, 32'h9);

    // Illegal opcode with a halting trap
    if1.opcode = 7'h7f; if1.mem_ready = 1'b1;
    next_cycle();
    if1.mem_ready = 1'b0;
    next_cycle();
    #1;
    check("illegal_trap", {28'd0, if1.trap, if1.pc_write, if1.trap_cause}, 32'h9);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      #1;
      if (if1.trap && if1.trap_cause == 2'd1) n++;
    end
    check("trap_hold_cycles", n, 20);
    rst_n = 1'b0;
    #1;
    check("reset_in_trap", {12'd0, outs1}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Fetch timeout: mem_ready held low
    if1.mem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (if1.trap) break;
      if (if1.mem_req) n++;
      next_cycle();
    end
    check("timeout_fetch_cycles", n, 16);
    check("timeout_cause", {30'd0, if1.trap_cause}, 2);
    rst_n = 1'b0;
    #1;
    check("reset_after_timeout", {12'd0, outs1}, 32'd0);

    // Non-halting trap on the second instance
    next_cycle();
    rst_n2 = 1'b1;
    #1;
    check("nh_idle", {12'd0, outs2}, 32'd0);
    next_cycle();
    #1;
    check("nh_fetch", {31'd0, if2.mem_req}, 32'd1);
    next_cycle();
    next_cycle();
    #1;
    check("nh_trap", {26'd0, if2.trap, if2.pc_write, if2.pc_src, if2.trap_cause}, 32'h31);
    next_cycle();
    #1;
    check("nh_refetch", {28'd0, if2.trap, if2.mem_req, if2.trap_cause}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
